// File: rtl/id_ex_stage_if.sv
// ID/EX bus: decoded ID operands, write-back bypass inputs and registered EX outputs.
// The slave modport is the stage's own view; the master modport belongs to the driver.
interface id_ex_stage_if #(
    parameter int WORD_SIZE    = 32,
    parameter int ADDRESS_SIZE = 5
);
    logic                    ValidD;
    logic [WORD_SIZE-1:0]    ReadData1;
    logic [WORD_SIZE-1:0]    ReadData2;
    logic [ADDRESS_SIZE-1:0] RsD;
    logic [ADDRESS_SIZE-1:0] RtD;
    logic [ADDRESS_SIZE-1:0] RdD;
    logic [WORD_SIZE-1:0]    ImmD;
    logic [WORD_SIZE-1:0]    PCPlus4D;
    logic [8:0]              CtrlD;
    logic                    WBRegWrite;
    logic [ADDRESS_SIZE-1:0] WBWriteReg;
    logic [WORD_SIZE-1:0]    WBWriteData;
    logic                    Flush;
    logic                    Stall;
    logic                    ValidE;
    logic [WORD_SIZE-1:0]    Op1E;
    logic [WORD_SIZE-1:0]    Op2E;
    logic [ADDRESS_SIZE-1:0] RsE;
    logic [ADDRESS_SIZE-1:0] RtE;
    logic [ADDRESS_SIZE-1:0] RdE;
    logic [WORD_SIZE-1:0]    ImmE;
    logic [WORD_SIZE-1:0]    PCPlus4E;
    logic [8:0]              CtrlE;

    modport slave (
        input  ValidD, ReadData1, ReadData2, RsD, RtD, RdD, ImmD, PCPlus4D, CtrlD,
        input  WBRegWrite, WBWriteReg, WBWriteData, Flush,
        output Stall, ValidE, Op1E, Op2E, RsE, RtE, RdE, ImmE, PCPlus4E, CtrlE
    );

    modport master (
        output ValidD, ReadData1, ReadData2, RsD, RtD, RdD, ImmD, PCPlus4D, CtrlD,
        output WBRegWrite, WBWriteReg, WBWriteData, Flush,
        input  Stall, ValidE, Op1E, Op2E, RsE, RtE, RdE, ImmE, PCPlus4E, CtrlE
    );
endinterface

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with write-back bypass, load-use stall
// and branch flush. The control bundle is {RegWrite, MemToReg, MemWrite, MemRead, ALUSrc, RegDst, ALUControl[2:0]}.
module id_ex_stage #(
    parameter int WORD_SIZE    = 32,
    parameter int ADDRESS_SIZE = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    id_ex_stage_if.slave  bus
);
    localparam int CTRL_MEMREAD = 5;

    logic                    valid_q, valid_d;
    logic [8:0]              ctrl_q, ctrl_d;
    logic [WORD_SIZE-1:0]    op_q   [2];
    logic [WORD_SIZE-1:0]    op_d   [2];
    logic [ADDRESS_SIZE-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [WORD_SIZE-1:0]    imm_q, imm_d, pc4_q, pc4_d;

    logic [ADDRESS_SIZE-1:0] src_spec [2];
    logic [WORD_SIZE-1:0]    rf_data  [2];
    logic [WORD_SIZE-1:0]    byp_data [2];
    logic                    stall;

    assign src_spec[0] = bus.RsD;
    assign src_spec[1] = bus.RtD;
    assign rf_data[0]  = bus.ReadData1;
    assign rf_data[1]  = bus.ReadData2;

    // The register file writes on the edge, so a same-cycle read is stale; register 0 is never bypassed.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bypass
            assign byp_data[gi] = (bus.WBRegWrite && (bus.WBWriteReg != '0) &&
                                   (bus.WBWriteReg == src_spec[gi])) ? bus.WBWriteData
                                                                      : rf_data[gi];
        end
    endgenerate

    // Conservative: RtD is compared even when it is an I-type destination.
    assign stall = valid_q && ctrl_q[CTRL_MEMREAD] && bus.ValidD && (rt_q != '0) &&
                   ((rt_q == bus.RsD) || (rt_q == bus.RtD)) && !bus.Flush;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        op_d[0] = op_q[0];
        op_d[1] = op_q[1];
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        imm_d   = imm_q;
        pc4_d   = pc4_q;
        if (bus.Flush || stall) begin
            // Bubble: only valid/control are cleared; data registers are don't-care.
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else begin
            valid_d = bus.ValidD;
            ctrl_d  = bus.ValidD ? bus.CtrlD : 9'd0;
            op_d[0] = byp_data[0];
            op_d[1] = byp_data[1];
            rs_d    = bus.RsD;
            rt_d    = bus.RtD;
            rd_d    = bus.RdD;
            imm_d   = bus.ImmD;
            pc4_d   = bus.PCPlus4D;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            op_q[0] <= '0;
            op_q[1] <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            imm_q   <= '0;
            pc4_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            op_q[0] <= op_d[0];
            op_q[1] <= op_d[1];
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            imm_q   <= imm_d;
            pc4_q   <= pc4_d;
        end
    end

    assign bus.Stall    = stall;
    assign bus.ValidE   = valid_q;
    assign bus.CtrlE    = ctrl_q;
    assign bus.Op1E     = op_q[0];
    assign bus.Op2E     = op_q[1];
    assign bus.RsE      = rs_q;
    assign bus.RtE      = rt_q;
    assign bus.RdE      = rd_q;
    assign bus.ImmE     = imm_q;
    assign bus.PCPlus4E = pc4_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: capture, bypass, load-use stall, flush priority,
// invalid slot and asynchronous reset, checked with immediate assertions.
module tb_id_ex_stage;
    localparam int WS = 32;
    localparam int AS = 5;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

    id_ex_stage_if #(.WORD_SIZE(WS), .ADDRESS_SIZE(AS)) bus ();

    id_ex_stage #(.WORD_SIZE(WS), .ADDRESS_SIZE(AS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.ValidD      = 1'b0;
        bus.ReadData1   = '0;
        bus.ReadData2   = '0;
        bus.RsD         = '0;
        bus.RtD         = '0;
        bus.RdD         = '0;
        bus.ImmD        = '0;
        bus.PCPlus4D    = '0;
        bus.CtrlD       = '0;
        bus.WBRegWrite  = 1'b0;
        bus.WBWriteReg  = '0;
        bus.WBWriteData = '0;
        bus.Flush       = 1'b0;
    endtask

    task automatic present(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [31:0] d1, input logic [31:0] d2, input logic [8:0] ctrl);
        bus.ValidD    = 1'b1;
        bus.RsD       = rs;
        bus.RtD       = rt;
        bus.RdD       = rd;
        bus.ReadData1 = d1;
        bus.ReadData2 = d2;
        bus.CtrlD     = ctrl;
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        idle();
        #2;
        check("reset_valid", 32'(bus.ValidE), 32'd0);
        check("reset_ctrl",  32'(bus.CtrlE),  32'd0);
        check("reset_stall", 32'(bus.Stall),  32'd0);
        check("reset_op1",   bus.Op1E,        32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Plain capture
        @(negedge clk);
        present(5'd3, 5'd4, 5'd6, 32'h1234, 32'h77, 9'h105);
        bus.ImmD     = 32'hFFFF_FFF0;
        bus.PCPlus4D = 32'h104;
        edge_sample();
        check("cap_op1",   bus.Op1E,             32'h1234);
        check("cap_op2",   bus.Op2E,             32'h77);
        check("cap_imm",   bus.ImmE,             32'hFFFF_FFF0);
        check("cap_pc4",   bus.PCPlus4E,         32'h104);
        check("cap_ctrl",  32'(bus.CtrlE),       32'h105);
        check("cap_valid", 32'(bus.ValidE),      32'd1);
        check("cap_rs",    32'(bus.RsE),         32'd3);
        check("cap_rt",    32'(bus.RtE),         32'd4);
        check("cap_rd",    32'(bus.RdE),         32'd6);
        check("cap_stall", 32'(bus.Stall),       32'd0);

        // Bypass on both operands
        @(negedge clk);
        present(5'd5, 5'd5, 5'd2, 32'h0, 32'h0, 9'h100);
        bus.WBRegWrite  = 1'b1;
        bus.WBWriteReg  = 5'd5;
        bus.WBWriteData = 32'hDEAD_BEEF;
        edge_sample();
        check("byp_op1", bus.Op1E, 32'hDEAD_BEEF);
        check("byp_op2", bus.Op2E, 32'hDEAD_BEEF);

        // Register 0 never bypassed
        @(negedge clk);
        present(5'd0, 5'd7, 5'd2, 32'h0, 32'h99, 9'h100);
        bus.WBWriteReg  = 5'd0;
        bus.WBWriteData = 32'h55;
        edge_sample();
        check("r0_op1", bus.Op1E, 32'h0);
        check("r0_op2", bus.Op2E, 32'h99);

        // Bypass only the rt operand
        @(negedge clk);
        present(5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 9'h100);
        bus.WBWriteReg  = 5'd2;
        bus.WBWriteData = 32'hABC;
        edge_sample();
        check("rt_byp_op1", bus.Op1E, 32'h11);
        check("rt_byp_op2", bus.Op2E, 32'hABC);

        // Matching register but write-back disabled: no bypass
        @(negedge clk);
        bus.WBRegWrite = 1'b0;
        edge_sample();
        check("nowb_op2", bus.Op2E, 32'h22);
        bus.WBWriteReg  = '0;
        bus.WBWriteData = '0;

        // Load-use: lw rt=8 then add rs=8
        @(negedge clk);
        present(5'd1, 5'd8, 5'd0, 32'h1000, 32'h0, 9'h1B0);
        edge_sample();
        check("lw_ctrl", 32'(bus.CtrlE), 32'h1B0);
        check("lw_rt",   32'(bus.RtE),   32'd8);
        @(negedge clk);
        present(5'd8, 5'd9, 5'd10, 32'h31, 32'h32, 9'h10A);
        #1;
        check("lu_stall", 32'(bus.Stall), 32'd1);
        edge_sample();
        check("lu_bub_valid", 32'(bus.ValidE), 32'd0);
        check("lu_bub_ctrl",  32'(bus.CtrlE),  32'd0);
        check("lu_bub_stall", 32'(bus.Stall),  32'd0);
        edge_sample();
        check("lu_add_valid", 32'(bus.ValidE), 32'd1);
        check("lu_add_ctrl",  32'(bus.CtrlE),  32'h10A);
        check("lu_add_rs",    32'(bus.RsE),    32'd8);
        check("lu_add_op1",   bus.Op1E,        32'h31);
        check("lu_add_stall", 32'(bus.Stall),  32'd0);

        // Flush beats stall
        @(negedge clk);
        present(5'd1, 5'd8, 5'd0, 32'h1000, 32'h0, 9'h1B0);
        edge_sample();
        @(negedge clk);
        present(5'd8, 5'd9, 5'd10, 32'h31, 32'h32, 9'h10A);
        #1;
        check("fl_pre_stall", 32'(bus.Stall), 32'd1);
        bus.Flush = 1'b1;
        #1;
        check("fl_stall", 32'(bus.Stall), 32'd0);
        edge_sample();
        check("fl_valid", 32'(bus.ValidE), 32'd0);
        check("fl_ctrl",  32'(bus.CtrlE),  32'd0);
        bus.Flush = 1'b0;

        // Invalid slot behind a load: no stall, no control propagated
        @(negedge clk);
        present(5'd1, 5'd8, 5'd0, 32'h1000, 32'h0, 9'h1B0);
        edge_sample();
        @(negedge clk);
        present(5'd8, 5'd8, 5'd4, 32'h0, 32'h0, 9'h1FF);
        bus.ValidD = 1'b0;
        #1;
        check("inv_stall", 32'(bus.Stall), 32'd0);
        edge_sample();
        check("inv_valid", 32'(bus.ValidE), 32'd0);
        check("inv_ctrl",  32'(bus.CtrlE),  32'd0);

        // Asynchronous reset mid-cycle with a live load in EX
        @(negedge clk);
        present(5'd1, 5'd3, 5'd0, 32'h44, 32'h0, 9'h1FF);
        edge_sample();
        check("pre_rst_ctrl", 32'(bus.CtrlE), 32'h1FF);
        present(5'd3, 5'd6, 5'd7, 32'h0, 32'h0, 9'h100);
        #1;
        check("pre_rst_stall", 32'(bus.Stall), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(bus.ValidE), 32'd0);
        check("arst_ctrl",  32'(bus.CtrlE),  32'd0);
        check("arst_stall", 32'(bus.Stall),  32'd0);
        check("arst_op1",   bus.Op1E,        32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        edge_sample();
        check("post_rst_valid", 32'(bus.ValidE), 32'd0);
        @(negedge clk);
        present(5'd2, 5'd3, 5'd4, 32'hCAFE, 32'hF00D, 9'h0C1);
        edge_sample();
        check("post_rst_op2",  bus.Op2E,        32'hF00D);
        check("post_rst_ctrl", 32'(bus.CtrlE),  32'h0C1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register. It sits directly downstream of the register file and captures its two read operands, the decoded immediate, PC+4, register specifiers and control bundle for the EX stage.
- It bypasses same-cycle write-back data, because the register file writes on the clock edge and a same-cycle read returns the stale value.
- It detects load-use hazards and inserts a bubble.
- It also handles branch flush.

Parameters:
- WORD_SIZE, 32, datapath width.
- ADDRESS_SIZE, 5, register specifier width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ValidD  in  1  ID slot holds a real instruction.
- ReadData1  in  WORD_SIZE  register file port 1 (rs).
- ReadData2  in  WORD_SIZE  register file port 2 (rt).
- RsD, RtD, RdD  in  ADDRESS_SIZE each  decoded specifiers.
- ImmD  in  WORD_SIZE  sign-extended immediate.
- PCPlus4D  in  WORD_SIZE  PC+4 of ID instruction.
- CtrlD  in  9  {RegWrite, MemToReg, MemWrite, MemRead, ALUSrc, RegDst, ALUControl[2:0]}.
- WBRegWrite  in  1  write-back write enable (same signal driving register file RegWrite).
- WBWriteReg  in  ADDRESS_SIZE  write-back destination.
- WBWriteData  in  WORD_SIZE  write-back data.
- Flush  in  1  branch/jump taken; kill ID instruction.
- Stall  out  1  combinational; freeze PC and IF/ID this cycle.
- ValidE  out  1  EX slot holds a real instruction.
- Op1E, Op2E  out  WORD_SIZE  bypass-corrected rs/rt values.
- RsE, RtE, RdE  out  ADDRESS_SIZE  registered specifiers.
- ImmE, PCPlus4E  out  WORD_SIZE  registered.
- CtrlE  out  9  registered control bundle.

Behaviour:
- Reset (rst_n low, asynchronous, immediate): all registered outputs are 0, and ValidE and CtrlE are 0. Stall therefore reads 0. Reset released mid-stream restarts with an empty EX slot.
- Latency is one cycle. ID values present before a rising edge appear on the E outputs after that edge.
- Bypass is combinational before capture:
  - Op1 source = WBWriteData if WBRegWrite & (WBWriteReg != 0) & (WBWriteReg == RsD); otherwise ReadData1.
  - Op2 uses the same rule with RtD and ReadData2.
  - Register 0 is never bypassed, so it always reads 0.
- Stall = ValidE & CtrlE.MemRead & ValidD & (RtE != 0) & ((RtE == RsD) | (RtE == RtD)) & ~Flush.
  - The check is conservative: it also fires when RtD is an I-type destination.
- Update at each rising edge, in priority order:
  - 1) Flush = 1: bubble.
  - 2) Stall = 1: bubble. The ID instruction is held upstream and re-presented next cycle.
  - 3) Otherwise: load all E registers from D inputs. ValidE <= ValidD. CtrlE <= CtrlD if ValidD, else 0.
- Bubble: ValidE <= 0 and CtrlE <= 0, so no RegWrite, MemWrite or MemRead propagates. Data and specifier registers hold their previous values and are don't-care.
- A load followed by a dependent instruction yields exactly one bubble cycle. On the next cycle EX holds the bubble (MemRead = 0), so Stall deasserts. Downstream forwarding then supplies the load result.
- Flush and Stall together: Flush wins and Stall is 0.
- No arithmetic or wrap is performed. Widths pass through unchanged.

Test Plan:
- Reset: assert rst_n = 0 mid-cycle with ValidE = 1 and CtrlE = 9'h1FF -> ValidE = 0, CtrlE = 0 and Stall = 0 immediately, without waiting for a clock edge.
- Plain capture: ValidD = 1, RsD = 3, ReadData1 = 32'h1234, ImmD = 32'hFFFF_FFF0, CtrlD = 9'h105, no WB -> after one edge Op1E = 32'h1234, ImmE = 32'hFFFF_FFF0, CtrlE = 9'h105, ValidE = 1.
- Bypass: RsD = 5, RtD = 5, ReadData1 = ReadData2 = 32'h0, WBRegWrite = 1, WBWriteReg = 5, WBWriteData = 32'hDEAD_BEEF -> Op1E = Op2E = 32'hDEAD_BEEF. Repeat with WBWriteReg = RsD = 0 and WBWriteData = 32'h55 -> Op1E = 32'h0.
- Load-use: issue lw with RtD = 8 (MemRead set), then add with RsD = 8 -> Stall = 1 for exactly one cycle. The next edge gives ValidE = 0 and CtrlE = 0. The following edge captures the add with ValidE = 1 and Stall = 0.
- Flush priority: set up the load-use condition and assert Flush = 1 in the same cycle -> Stall = 0, and after the edge ValidE = 0 and CtrlE = 0.
- Invalid slot: ValidD = 0 with CtrlD = 9'h1FF -> after the edge ValidE = 0 and CtrlE = 0. No stall is raised even if RsD matches a load RtE.
